// File: rtl/tail_input_conditioner.sv
// Tail-light front end: synchronizes and debounces the turn switches, generates
// the step tick, and presents tick-aligned left/right requests that latch short presses.

module tail_input_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic db,
  output logic req
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s;
  logic [CW-1:0] cnt;
  logic          db_prev;
  logic          pend;
  logic          rise;

  assign rise = db & ~db_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1      <= 1'b0;
      s       <= 1'b0;
      cnt     <= '0;
      db      <= 1'b0;
      db_prev <= 1'b0;
      pend    <= 1'b0;
      req     <= 1'b0;
    end else begin
      s1 <= raw;
      s  <= s1;

      // Any cycle where s agrees with db restarts the stability count.
      if (s == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end

      db_prev <= db;

      // A rise in the tick cycle itself is already visible through db.
      if (tick) begin
        pend <= 1'b0;
      end else if (rise) begin
        pend <= 1'b1;
      end

      if (tick) begin
        req <= db | pend;
      end
    end
  end

endmodule

module tail_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned TICK_CYCLES     = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic left_raw,
  input  logic right_raw,
  output logic tick,
  output logic left,
  output logic right,
  output logic left_db,
  output logic right_db
);

  localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0] TCNT_PRE  = TW'(TICK_CYCLES - 2);

  logic [TW-1:0] tcnt;

  // tick is a flop loaded one count early, so it is high exactly while tcnt == TICK_CYCLES-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
      tick <= 1'b0;
    end else begin
      if (tcnt == TCNT_LAST) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
      tick <= (tcnt == TCNT_PRE);
    end
  end

  tail_input_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_left (
    .clk  (clk),
    .reset(reset),
    .raw  (left_raw),
    .tick (tick),
    .db   (left_db),
    .req  (left)
  );

  tail_input_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_right (
    .clk  (clk),
    .reset(reset),
    .raw  (right_raw),
    .tick (tick),
    .db   (right_db),
    .req  (right)
  );

endmodule
